// File: rtl/spi_sibal_pkg.sv
// Shared types and constants for the spi_sibal SPI master transfer controller.
package spi_sibal_pkg;

  localparam int BYTE_W        = 8;
  localparam int HALF_PER_BYTE = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    SHIFT,
    HOLD
  } xfer_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] v, input logic b);
    return {v[BYTE_W-2:0], b};
  endfunction

endpackage

// File: rtl/spi_sibal_clkgen.sv
// SCLK half-period timer: strobes at the end of each half-period and tracks the
// half-period index within a byte. Held cleared while disabled, so it restarts on enable.
module spi_sibal_clkgen (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] div_i,
  output logic       lead_stb_o,
  output logic       trail_stb_o,
  output logic [3:0] half_idx_o
);

  logic [7:0] cnt_q;
  logic [3:0] idx_q;
  logic       end_hp;

  assign end_hp      = en_i && (cnt_q == div_i);
  assign lead_stb_o  = end_hp && !idx_q[0];
  assign trail_stb_o = end_hp && idx_q[0];
  assign half_idx_o  = idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (!en_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (end_hp) begin
      cnt_q <= '0;
      idx_q <= idx_q + 4'd1;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_sibal_xfer_ctrl.sv
// SPI master transfer sequencer: command latch, CS setup/hold, byte loop, MSB-first shifter.
// Optional build macro SPI_LOOPBACK_EN adds cfg_loopback (sample MOSI instead of MISO).
module spi_sibal_xfer_ctrl
  import spi_sibal_pkg::*;
#(
  parameter int NUM_CS       = 4,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  localparam int CS_W        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_len,
  input  logic              cmd_cpol,
  input  logic              cmd_cpha,
  input  logic [7:0]        cmd_div,
  input  logic [CS_W-1:0]   cmd_cs_sel,
`ifdef SPI_LOOPBACK_EN
  input  logic              cfg_loopback,
`endif
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [7:0]        tx_data,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD_CYC - 1);
  localparam logic [3:0] LAST_HALF  = 4'(HALF_PER_BYTE - 1);

  xfer_state_e       state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [7:0]        div_q, div_d;
  logic [3:0]        bcnt_q, bcnt_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [BYTE_W-1:0] rxd_q, rxd_d;
  logic              rxv_q, rxv_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] csn_q, csn_d;

  logic       lead_stb, trail_stb;
  logic [3:0] half_idx;
  logic       sample_stb, shift_stb, sample_bit;

  // Out-of-range selects leave every line deasserted so the bus can be probed.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) r[i] = 1'b0;
    end
    return r;
  endfunction

  spi_sibal_clkgen u_clkgen (
    .clk_i       (ACLK),
    .rst_ni      (ARESETN),
    .en_i        (state_q == SHIFT),
    .div_i       (div_q),
    .lead_stb_o  (lead_stb),
    .trail_stb_o (trail_stb),
    .half_idx_o  (half_idx)
  );

`ifdef SPI_LOOPBACK_EN
  logic lb_q, lb_d;
  assign sample_bit = lb_q ? mosi_q : spi_miso;
`else
  assign sample_bit = spi_miso;
`endif

  // CPHA=0 keeps the last data bit on MOSI instead of shifting after the final edge.
  assign sample_stb = mode_q.cpha ? trail_stb : lead_stb;
  assign shift_stb  = mode_q.cpha ? lead_stb : (trail_stb && (half_idx != LAST_HALF));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    bcnt_d  = bcnt_q;
    pcnt_d  = pcnt_q;
    shreg_d = shreg_q;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
`ifdef SPI_LOOPBACK_EN
    lb_d    = lb_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          mode_d  = '{cpol: cmd_cpol, cpha: cmd_cpha};
          div_d   = cmd_div;
          bcnt_d  = cmd_len;
          pcnt_d  = '0;
          sclk_d  = cmd_cpol;
          csn_d   = cs_decode(cmd_cs_sel);
`ifdef SPI_LOOPBACK_EN
          lb_d    = cfg_loopback;
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (pcnt_q == SETUP_LAST) state_d = LOAD;
        else pcnt_d = pcnt_q + 8'd1;
      end
      LOAD: begin
        if (tx_valid) begin
          shreg_d = tx_data;
          if (!mode_q.cpha) mosi_d = tx_data[BYTE_W-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (lead_stb || trail_stb) sclk_d = ~sclk_q;
        if (sample_stb) shreg_d = shift_in(shreg_q, sample_bit);
        if (shift_stb) mosi_d = shreg_q[BYTE_W-1];
        if (trail_stb && (half_idx == LAST_HALF)) begin
          rxd_d = shreg_d;
          rxv_d = 1'b1;
          if (bcnt_q == 4'd0) begin
            pcnt_d  = '0;
            state_d = HOLD;
          end else begin
            bcnt_d  = bcnt_q - 4'd1;
            state_d = LOAD;
          end
        end
      end
      HOLD: begin
        if (pcnt_q == HOLD_LAST) begin
          csn_d   = '1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          pcnt_d = pcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      mode_q  <= '0;
      div_q   <= '0;
      bcnt_q  <= '0;
      pcnt_q  <= '0;
      shreg_q <= '0;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= '1;
`ifdef SPI_LOOPBACK_EN
      lb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      bcnt_q  <= bcnt_d;
      pcnt_q  <= pcnt_d;
      shreg_q <= shreg_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
`ifdef SPI_LOOPBACK_EN
      lb_q    <= lb_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tx_ready  = (state_q == LOAD);
  assign rx_valid  = rxv_q;
  assign rx_data   = rxd_q;
  assign done      = done_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs_n  = csn_q;

endmodule

// File: tb/tb_spi_sibal_xfer_ctrl.sv
// Directed bench for spi_sibal_xfer_ctrl (NUM_CS=3 so an out-of-range select is encodable).
module tb_spi_sibal_xfer_ctrl;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_len = '0;
  logic       cmd_cpol = 1'b0;
  logic       cmd_cpha = 1'b0;
  logic [7:0] cmd_div = '0;
  logic [1:0] cmd_cs_sel = '0;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [2:0] spi_cs_n;

  int ncomp = 0;
  int nerr  = 0;

  // Stimulus-side sources and monitors
  logic [7:0] tx_arr [16];
  int         tx_hs = 0, tx_base = 0, tx_n = 0;
  logic       tx_en = 1'b0;
  logic       miso_slv = 1'b0;
  logic [7:0] slv_pat = 8'h5A;
  int         neg_total = 0, neg_base = 0;
  int         rise_total = 0, tog_total = 0;
  int         rx_total = 0, done_total = 0, cs1_low = 0, csany_low = 0;
  logic [7:0] rx_log [64];
  logic       slv_bit;

  assign tx_valid = tx_en && ((tx_hs - tx_base) < tx_n);
  assign tx_data  = tx_arr[(tx_hs - tx_base) & 15];
  assign slv_bit  = slv_pat[7 - ((neg_total - neg_base - 1) & 7)];
  assign spi_miso = miso_slv ? slv_bit : spi_mosi;

  always #5 ACLK = ~ACLK;

  spi_sibal_xfer_ctrl #(.NUM_CS(3), .CS_SETUP_CYC(2), .CS_HOLD_CYC(2)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_cpol   (cmd_cpol),
    .cmd_cpha   (cmd_cpha),
    .cmd_div    (cmd_div),
    .cmd_cs_sel (cmd_cs_sel),
`ifdef SPI_LOOPBACK_EN
    .cfg_loopback(1'b0),
`endif
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .busy       (busy),
    .done       (done),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_cs_n   (spi_cs_n)
  );

  always @(posedge ACLK) begin
    if (tx_valid && tx_ready) tx_hs <= tx_hs + 1;
    if (rx_valid) begin
      rx_log[rx_total & 63] <= rx_data;
      rx_total <= rx_total + 1;
    end
    if (done) done_total <= done_total + 1;
    if (!spi_cs_n[1]) cs1_low <= cs1_low + 1;
    if (spi_cs_n != 3'b111) csany_low <= csany_low + 1;
  end

  always @(posedge spi_sclk) rise_total <= rise_total + 1;
  always @(negedge spi_sclk) neg_total <= neg_total + 1;
  always @(spi_sclk) tog_total <= tog_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    ncomp++;
    nerr++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic issue_cmd(input logic [3:0] len, input logic cpol, input logic cpha,
                           input logic [7:0] div, input logic [1:0] sel);
    int n;
    n = 0;
    while (!cmd_ready && n < 2000) begin step(); n++; end
    if (!cmd_ready) timeout("cmd_ready_wait");
    cmd_len = len; cmd_cpol = cpol; cmd_cpha = cpha; cmd_div = div; cmd_cs_sel = sel;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin step(); n++; end
    if (!done) timeout(tag);
  endtask

  task automatic load_tx(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input int n);
    tx_arr[0] = b0; tx_arr[1] = b1; tx_arr[2] = b2; tx_arr[3] = b3;
    tx_base = tx_hs;
    tx_n = n;
    tx_en = 1'b1;
  endtask

  initial begin
    int r0, d0, c0, s0, t0, a0, h0, n, bad;
    for (int i = 0; i < 16; i++) tx_arr[i] = '0;

    // Reset state
    step(); step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_cs_n", spi_cs_n, 3'b111);
    ARESETN = 1'b1;
    step();

    // 1: mode 0 single byte, MISO looped from MOSI
    load_tx(8'hA5, 8'h00, 8'h00, 8'h00, 1);
    r0 = rx_total; d0 = done_total; c0 = cs1_low;
    issue_cmd(4'd0, 1'b0, 1'b0, 8'd1, 2'd1);
    check("t1_cs_n_setup", spi_cs_n, 3'b101);
    check("t1_busy", busy, 1);
    wait_done("t1_done_wait", 400);
    step();
    check("t1_rx_count", rx_total - r0, 1);
    check("t1_rx_byte", rx_log[r0 & 63], 8'hA5);
    check("t1_cs_low_cycles", cs1_low - c0, 37);
    check("t1_done_pulses", done_total - d0, 1);
    check("t1_done_cleared", done, 0);

    // 2: mode 3 burst against a slave returning 0x5A
    load_tx(8'h01, 8'h80, 8'hFF, 8'h3C, 4);
    miso_slv = 1'b1;
    neg_base = neg_total;
    r0 = rx_total; d0 = done_total; h0 = tx_hs;
    issue_cmd(4'd3, 1'b1, 1'b1, 8'd2, 2'd0);
    s0 = rise_total;
    check("t2_sclk_idle_high", spi_sclk, 1);
    wait_done("t2_done_wait", 1000);
    step();
    check("t2_rx_count", rx_total - r0, 4);
    check("t2_rx0", rx_log[r0 & 63], 8'h5A);
    check("t2_rx3", rx_log[(r0 + 3) & 63], 8'h5A);
    check("t2_rising_edges", rise_total - s0, 32);
    check("t2_sclk_end_high", spi_sclk, 1);
    check("t2_tx_consumed", tx_hs - h0, 4);
    miso_slv = 1'b0;

    // 3: TX underflow between two bytes
    load_tx(8'h12, 8'hE7, 8'h00, 8'h00, 1);
    r0 = rx_total; d0 = done_total;
    issue_cmd(4'd1, 1'b0, 1'b0, 8'd2, 2'd2);
    n = 0;
    while (!rx_valid && n < 300) begin step(); n++; end
    if (!rx_valid) timeout("t3_first_rx_wait");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_ready !== 1'b1 || spi_sclk !== 1'b0 || spi_cs_n !== 3'b011) bad++;
      step();
    end
    check("t3_gap_violations", bad, 0);
    check("t3_no_done_in_gap", done_total - d0, 0);
    tx_n = 2;
    wait_done("t3_done_wait", 400);
    step();
    check("t3_rx0", rx_log[r0 & 63], 8'h12);
    check("t3_rx1", rx_log[(r0 + 1) & 63], 8'hE7);
    check("t3_done_pulses", done_total - d0, 1);

    // 4: second command held during a busy transfer
    load_tx(8'h55, 8'hAA, 8'h00, 8'h00, 2);
    r0 = rx_total;
    cmd_len = 4'd0; cmd_cpol = 1'b0; cmd_cpha = 1'b0; cmd_div = 8'd0; cmd_cs_sel = 2'd0;
    cmd_valid = 1'b1;
    step();
    cmd_cs_sel = 2'd2;
    step(); step();
    check("t4_cmd_ready_busy", cmd_ready, 0);
    check("t4_cs_first", spi_cs_n, 3'b110);
    wait_done("t4_done1_wait", 200);
    check("t4_ready_on_done", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    check("t4_second_accepted", busy, 1);
    check("t4_cs_second", spi_cs_n, 3'b011);
    wait_done("t4_done2_wait", 200);
    step();
    check("t4_rx0", rx_log[r0 & 63], 8'h55);
    check("t4_rx1", rx_log[(r0 + 1) & 63], 8'hAA);

    // 5: asynchronous reset in the middle of a byte, then a clean transfer
    load_tx(8'hC3, 8'h00, 8'h00, 8'h00, 1);
    r0 = rx_total; d0 = done_total;
    issue_cmd(4'd0, 1'b0, 1'b0, 8'd3, 2'd1);
    s0 = rise_total;
    n = 0;
    while ((rise_total - s0) < 5 && n < 300) begin step(); n++; end
    if ((rise_total - s0) < 5) timeout("t5_edge_wait");
    #2;
    ARESETN = 1'b0;
    #1;
    check("t5_cs_n_reset", spi_cs_n, 3'b111);
    check("t5_sclk_reset", spi_sclk, 0);
    check("t5_busy_reset", busy, 0);
    check("t5_rx_valid_reset", rx_valid, 0);
    step(); step();
    ARESETN = 1'b1;
    step(); step();
    check("t5_no_rx", rx_total - r0, 0);
    check("t5_no_done", done_total - d0, 0);
    load_tx(8'h96, 8'h00, 8'h00, 8'h00, 1);
    issue_cmd(4'd0, 1'b0, 1'b0, 8'd1, 2'd0);
    wait_done("t5_done_wait", 300);
    step();
    check("t5_rx_after_reset", rx_log[r0 & 63], 8'h96);
    check("t5_done_after_reset", done_total - d0, 1);

    // 6: out-of-range select, fastest SCLK, 16-byte burst
    for (int i = 0; i < 16; i++) tx_arr[i] = 8'(i * 17);
    tx_base = tx_hs; tx_n = 16; tx_en = 1'b1;
    r0 = rx_total; d0 = done_total; a0 = csany_low; t0 = tog_total;
    issue_cmd(4'd15, 1'b0, 1'b0, 8'd0, 2'd3);
    wait_done("t6_done_wait", 2000);
    step();
    check("t6_rx_count", rx_total - r0, 16);
    check("t6_rx0", rx_log[r0 & 63], 8'h00);
    check("t6_rx15", rx_log[(r0 + 15) & 63], 8'hFF);
    check("t6_sclk_toggles", tog_total - t0, 256);
    check("t6_cs_never_low", csany_low - a0, 0);
    check("t6_done_pulses", done_total - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nerr);
    $finish;
  end

endmodule
